// File: rtl/tiles_pkg.sv
// Shared types and keycode constants for the tile playfield front end.
// Lane events carry a 3-bit lane and a bad-key flag.
package tiles_pkg;

  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_F     = 8'h09;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_J     = 8'h0D;
  localparam logic [7:0] KEY_K     = 8'h0E;

  localparam logic [2:0] LANE_BAD = 3'd7;

  typedef struct packed {
    logic [2:0] lane;
    logic       bad;
  } key_ev_t;

  function automatic key_ev_t decode_key(
    input logic [7:0] kc
  );
    key_ev_t ev;
    ev.lane = LANE_BAD;
    ev.bad  = 1'b1;
    unique case (1'b1)
      (kc == KEY_D):     ev = '{lane: 3'd0, bad: 1'b0};
      (kc == KEY_F):     ev = '{lane: 3'd1, bad: 1'b0};
      (kc == KEY_SPACE): ev = '{lane: 3'd2, bad: 1'b0};
      (kc == KEY_J):     ev = '{lane: 3'd3, bad: 1'b0};
      (kc == KEY_K):     ev = '{lane: 3'd4, bad: 1'b0};
      default: ;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/ev_fifo.sv
// Small lane-event FIFO; pointers wrap naturally, full/empty from count.
// A push into a full FIFO is taken only when a pop frees a slot.
module ev_fifo
  import tiles_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   vs,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  key_ev_t                din,
  output key_ev_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  key_ev_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge vs or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: the head is gated by empty.
  always_ff @(posedge vs) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/key_events.sv
// Per-frame keycode sampler: edge-detects presses into lane events,
// buffers them for the tile renderer, flags drops and stuck keys.
module key_events
  import tiles_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int HOLD_MAX = 60
) (
  input  logic                   vs,
  input  logic                   Reset,
  input  logic [7:0]             keycode,
  input  logic                   ev_ready,
  output logic                   ev_valid,
  output logic [2:0]             ev_lane,
  output logic [4:0]             ev_onehot,
  output logic                   ev_bad,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   stuck
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  logic [7:0]    key_q;
  logic [HW-1:0] hold;
  logic          press;
  logic          pop;
  logic          full;
  logic          empty;
  key_ev_t       head;

  assign press = (keycode != 8'h00) && (keycode != key_q);
  assign pop   = ev_valid && ev_ready;
  assign stuck = (hold == HW'(HOLD_MAX));

  ev_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .vs    (vs),
    .Reset (Reset),
    .push  (press),
    .pop   (pop),
    .din   (decode_key(keycode)),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge vs or posedge Reset) begin
    if (Reset) begin
      key_q    <= 8'h00;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      key_q <= keycode;
      if (press && full && !pop) overflow <= 1'b1;
      // Not a press and non-zero means the same key is still held.
      if (press || keycode == 8'h00) hold <= '0;
      else if (!stuck) hold <= hold + HW'(1);
    end
  end

  always_comb begin
    ev_valid  = !empty;
    ev_lane   = 3'd0;
    ev_onehot = 5'b00000;
    ev_bad    = 1'b0;
    if (!empty) begin
      ev_lane = head.lane;
      ev_bad  = head.bad;
      if (!head.bad) ev_onehot = 5'(1) << head.lane;
    end
  end

endmodule

// File: tb/tb_key_events.sv
// Randomised and directed bench for key_events against a queue model.
// The model tracks the event list, previous key and hold count.
module tb_key_events;

  localparam int DEPTH    = 4;
  localparam int HOLD_MAX = 60;

  logic       vs = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_lane;
  logic [4:0] ev_onehot;
  logic       ev_bad;
  logic [2:0] count;
  logic       overflow;
  logic       stuck;

  int checks = 0;
  int errors = 0;

  // Model: queue of lanes, -1 stands for a bad key.
  int q[$];
  int m_key = 0;
  int m_hold = 0;
  bit m_ovf = 0;

  key_events #(
    .DEPTH(DEPTH),
    .HOLD_MAX(HOLD_MAX)
  ) dut (
    .vs        (vs),
    .Reset     (Reset),
    .keycode   (keycode),
    .ev_ready  (ev_ready),
    .ev_valid  (ev_valid),
    .ev_lane   (ev_lane),
    .ev_onehot (ev_onehot),
    .ev_bad    (ev_bad),
    .count     (count),
    .overflow  (overflow),
    .stuck     (stuck)
  );

  always #5 vs = ~vs;

  function automatic int lane_of(int kc);
    case (kc)
      8'h07:   return 0;
      8'h09:   return 1;
      8'h2C:   return 2;
      8'h0D:   return 3;
      8'h0E:   return 4;
      default: return -1;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge vs or posedge Reset) begin
    if (Reset) begin
      q.delete();
      m_key  = 0;
      m_hold = 0;
      m_ovf  = 0;
    end else begin
      int  kc;
      int  n;
      bit  press;
      bit  popd;
      kc    = int'(keycode);
      n     = q.size();
      press = (kc != 0) && (kc != m_key);
      popd  = (n > 0) && ev_ready;
      if (popd) void'(q.pop_front());
      if (press) begin
        if (n < DEPTH || popd) q.push_back(lane_of(kc));
        else m_ovf = 1;
      end
      if (press || kc == 0) m_hold = 0;
      else if (m_hold < HOLD_MAX) m_hold++;
      m_key = kc;
    end
  end

  always @(negedge vs) begin
    if (!Reset) begin
      int hl;
      hl = (q.size() > 0) ? q[0] : 0;
      chk("valid", int'(ev_valid), int'(q.size() > 0));
      chk("count", int'(count), q.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("stuck", int'(stuck), int'(m_hold == HOLD_MAX));
      if (q.size() == 0) begin
        chk("lane_e", int'(ev_lane), 0);
        chk("oh_e", int'(ev_onehot), 0);
        chk("bad_e", int'(ev_bad), 0);
      end else begin
        chk("lane", int'(ev_lane), (hl < 0) ? 7 : hl);
        chk("onehot", int'(ev_onehot), (hl < 0) ? 0 : (1 << hl));
        chk("bad", int'(ev_bad), int'(hl < 0));
      end
    end
  end

  task automatic frame(input logic [7:0] kc, input logic rdy);
    keycode  = kc;
    ev_ready = rdy;
    @(negedge vs);
  endtask

  initial begin
    logic [7:0] kc;
    logic [7:0] pool [8];
    pool = '{8'h00, 8'h07, 8'h09, 8'h2C, 8'h0D, 8'h0E, 8'h04, 8'h00};

    #12;
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(negedge vs);
    Reset = 1'b0;

    // Single tap.
    frame(8'h07, 1'b0);
    chk("tap_lane", int'(ev_lane), 0);
    chk("tap_oh", int'(ev_onehot), 1);
    chk("tap_bad", int'(ev_bad), 0);
    frame(8'h00, 1'b0);
    chk("tap_cnt", int'(count), 1);
    frame(8'h00, 1'b1);
    chk("tap_pop", int'(ev_valid), 0);

    // Long hold.
    for (int i = 1; i <= 70; i++) begin
      frame(8'h0E, 1'b0);
      if (i == 60) chk("stuck_60", int'(stuck), 0);
      if (i == 61) chk("stuck_61", int'(stuck), 1);
    end
    chk("hold_cnt", int'(count), 1);
    chk("hold_lane", int'(ev_lane), 4);
    frame(8'h00, 1'b1);
    chk("unstuck", int'(stuck), 0);
    chk("hold_pop", int'(ev_valid), 0);

    // Direct changes without release.
    frame(8'h09, 1'b0);
    frame(8'h2C, 1'b0);
    frame(8'h0D, 1'b0);
    chk("seq_cnt", int'(count), 3);
    chk("seq_l1", int'(ev_lane), 1);
    frame(8'h0D, 1'b1);
    chk("seq_l2", int'(ev_lane), 2);
    frame(8'h00, 1'b1);
    chk("seq_l3", int'(ev_lane), 3);
    frame(8'h00, 1'b1);
    chk("seq_empty", int'(ev_valid), 0);

    // Non-lane key.
    frame(8'h04, 1'b0);
    chk("bad_lane", int'(ev_lane), 7);
    chk("bad_oh", int'(ev_onehot), 0);
    chk("bad_flag", int'(ev_bad), 1);
    frame(8'h00, 1'b1);

    // Overflow, then full with push and pop together.
    for (int i = 0; i < 6; i++) begin
      frame(8'h07, 1'b0);
      frame(8'h00, 1'b0);
    end
    chk("ovf_cnt", int'(count), 4);
    chk("ovf_flag", int'(overflow), 1);
    frame(8'h0D, 1'b1);
    chk("full_pp_cnt", int'(count), 4);
    chk("full_pp_lane", int'(ev_lane), 0);
    frame(8'h00, 1'b1);
    frame(8'h00, 1'b1);
    frame(8'h00, 1'b1);
    chk("full_pp_tail", int'(ev_lane), 3);
    chk("full_pp_c1", int'(count), 1);
    chk("ovf_sticky", int'(overflow), 1);
    frame(8'h00, 1'b1);

    // Asynchronous reset mid-press.
    frame(8'h07, 1'b0);
    frame(8'h09, 1'b0);
    frame(8'h0D, 1'b0);
    chk("pre_rst_cnt", int'(count), 3);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_valid", int'(ev_valid), 0);
    chk("arst_cnt", int'(count), 0);
    chk("arst_ovf", int'(overflow), 0);
    chk("arst_lane", int'(ev_lane), 0);
    #1;
    Reset = 1'b0;
    frame(8'h0D, 1'b0);
    chk("post_rst_cnt", int'(count), 1);
    chk("post_rst_lane", int'(ev_lane), 3);
    frame(8'h00, 1'b1);

    // Random traffic.
    kc = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 45) begin
        if ($urandom_range(7) == 7) kc = 8'($urandom);
        else kc = pool[$urandom_range(7)];
      end
      if ($urandom_range(399) == 0) begin
        #2;
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
      end
      frame(kc, 1'($urandom_range(99) < 35));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
